// File: rtl/alsu_result_tx.sv
// alsu_result_tx: captures deduplicated ALSU results into a small FIFO and
// drains them onto a UART-style serial line (start, 6 data LSB-first,
// even parity, stop). Each serial bit lasts CLKS_PER_BIT clocks.
module alsu_result_tx #(
  parameter int DEPTH        = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_alsu_valid,
  input  logic [5:0]               i_alsu_out,
  input  logic                     i_tx_en,
  output logic                     o_tx,
  output logic                     o_tx_busy,
  output logic [$clog2(DEPTH):0]   o_fifo_count,
  output logic                     o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [DW-1:0] DIV_LAST   = DW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);
  localparam logic [2:0]    LAST_BIT   = 3'd5;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  // Even parity bit: makes the total number of ones (data + parity) even.
  function automatic logic even_parity(input logic [5:0] d);
    return ^d;
  endfunction

  // Capture / dedupe registers
  logic             r_valid_d;
  logic [5:0]       r_last_out;

  // FIFO storage and bookkeeping
  logic [5:0]       r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;

  // Serializer state
  logic [2:0]       r_state;
  logic [DW-1:0]    r_div_cnt;
  logic [2:0]       r_bit_cnt;
  logic [5:0]       r_shift;
  logic             r_parity;
  logic             r_tx;
  logic             r_busy;

  // Combinational helpers
  logic             w_push;
  logic             w_full;
  logic             w_wr_en;
  logic             w_pop;
  logic             w_can_start;
  logic             w_div_last;
  logic [5:0]       w_head;
  logic [2:0]       w_state_next;
  logic [DW-1:0]    w_div_next;
  logic [2:0]       w_bit_next;
  logic [5:0]       w_shift_next;
  logic             w_parity_next;
  logic             w_tx_next;

  // A result is new when valid rises, or the value changes while valid stays high.
  assign w_push      = i_alsu_valid && (!r_valid_d || (i_alsu_out != r_last_out));
  assign w_full      = (r_count == COUNT_FULL);
  // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
  assign w_wr_en     = w_push && (!w_full || w_pop);
  assign w_can_start = (r_count != {CW{1'b0}}) && i_tx_en;
  assign w_div_last  = (r_div_cnt == DIV_LAST);
  assign w_head      = r_mem[r_rd_ptr];

  assign o_tx         = r_tx;
  assign o_tx_busy    = r_busy;
  assign o_fifo_count = r_count;
  assign o_overflow   = r_overflow;

  // Track previous valid/value for the dedupe comparison.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid_d  <= 1'b0;
      r_last_out <= 6'd0;
    end else begin
      r_valid_d  <= i_alsu_valid;
      r_last_out <= i_alsu_out;
    end
  end

  // FIFO storage write; contents are don't-care until written, so no reset.
  always_ff @(posedge i_clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= i_alsu_out;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr   <= {AW{1'b0}};
      r_rd_ptr   <= {AW{1'b0}};
      r_count    <= {CW{1'b0}};
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_wr_en, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_push && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Next-state logic for the serializer, including pop decisions.
  always_comb begin
    w_state_next  = r_state;
    w_div_next    = r_div_cnt;
    w_bit_next    = r_bit_cnt;
    w_shift_next  = r_shift;
    w_parity_next = r_parity;
    w_pop         = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_div_next = {DW{1'b0}};
        if (w_can_start) begin
          w_pop         = 1'b1;
          w_shift_next  = w_head;
          w_parity_next = even_parity(w_head);
          w_state_next  = S_START;
        end else begin
          w_state_next  = S_IDLE;
        end
      end
      S_START: begin
        if (w_div_last) begin
          w_div_next   = {DW{1'b0}};
          w_bit_next   = 3'd0;
          w_state_next = S_DATA;
        end else begin
          w_div_next   = r_div_cnt + DW'(1);
        end
      end
      S_DATA: begin
        if (w_div_last) begin
          w_div_next   = {DW{1'b0}};
          w_shift_next = {1'b0, r_shift[5:1]};
          if (r_bit_cnt == LAST_BIT) begin
            w_bit_next   = 3'd0;
            w_state_next = S_PARITY;
          end else begin
            w_bit_next   = r_bit_cnt + 3'd1;
          end
        end else begin
          w_div_next   = r_div_cnt + DW'(1);
        end
      end
      S_PARITY: begin
        if (w_div_last) begin
          w_div_next   = {DW{1'b0}};
          w_state_next = S_STOP;
        end else begin
          w_div_next   = r_div_cnt + DW'(1);
        end
      end
      S_STOP: begin
        if (w_div_last) begin
          w_div_next = {DW{1'b0}};
          // Back-to-back: chain straight into the next start bit.
          if (w_can_start) begin
            w_pop         = 1'b1;
            w_shift_next  = w_head;
            w_parity_next = even_parity(w_head);
            w_state_next  = S_START;
          end else begin
            w_state_next  = S_IDLE;
          end
        end else begin
          w_div_next = r_div_cnt + DW'(1);
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_div_next   = {DW{1'b0}};
        w_bit_next   = 3'd0;
      end
    endcase
  end

  // Line level for the upcoming cycle, so tx itself can be a register.
  always_comb begin
    w_tx_next = 1'b1;
    case (w_state_next)
      S_IDLE:   w_tx_next = 1'b1;
      S_START:  w_tx_next = 1'b0;
      S_DATA:   w_tx_next = w_shift_next[0];
      S_PARITY: w_tx_next = w_parity_next;
      S_STOP:   w_tx_next = 1'b1;
      default:  w_tx_next = 1'b1;
    endcase
  end

  // Serializer state and registered line outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_div_cnt <= {DW{1'b0}};
      r_bit_cnt <= 3'd0;
      r_shift   <= 6'd0;
      r_parity  <= 1'b0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_div_cnt <= w_div_next;
      r_bit_cnt <= w_bit_next;
      r_shift   <= w_shift_next;
      r_parity  <= w_parity_next;
      r_tx      <= w_tx_next;
      r_busy    <= (w_state_next != S_IDLE);
    end
  end

endmodule
